// File: rtl/rvfi_mon_pkg.sv
// rvfi_mon_pkg: shared types and constants for the RVFI retirement-sequence monitor
package rvfi_mon_pkg;
  localparam int XLEN = 32;
  localparam int ORDER_W = 64;
  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HALTED, S_ERROR} state_t;
  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_ORDER = 3'd1,
    ERR_PC    = 3'd2,
    ERR_ALIGN = 3'd3,
    ERR_HALT  = 3'd4
  } err_code_t;
endpackage

// File: rtl/rvfi_pc_hist.sv
// rvfi_pc_hist: circular retired-PC history; push writes newest, idx 0 reads newest
// ports: clock, reset_n (async active-low), push, din[XLEN], idx[log2 DEPTH], dout[XLEN]
module rvfi_pc_hist
  import rvfi_mon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [XLEN-1:0]          din,
  input  logic [$clog2(DEPTH)-1:0] idx,
  output logic [XLEN-1:0]          dout
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  // power-of-2 depth: pointer arithmetic wraps naturally
  assign rptr = wptr - AW'(1) - idx;
  // storage is cleared on reset, so unwritten entries read 0
  assign dout = mem[rptr];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= din;
      wptr <= wptr + AW'(1);
    end
  end
endmodule

// File: rtl/rvfi_seq_monitor.sv
// rvfi_seq_monitor: checks RVFI retirement order, PC chaining, alignment and post-halt activity
// ports: clock, reset_n (async active-low); rvfi_valid/order/pc_rdata/pc_wdata/trap/halt in;
//        hist_idx in / hist_pc out (retired-PC history); retired_cnt, err, err_code, err_order out
module rvfi_seq_monitor
  import rvfi_mon_pkg::*;
#(
  parameter int CHECK_ALIGN = 1,
  parameter int HIST_DEPTH  = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rvfi_valid,
  input  logic [ORDER_W-1:0]            rvfi_order,
  input  logic [XLEN-1:0]               rvfi_pc_rdata,
  input  logic [XLEN-1:0]               rvfi_pc_wdata,
  input  logic                          rvfi_trap,
  input  logic                          rvfi_halt,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [XLEN-1:0]               hist_pc,
  output logic [31:0]                   retired_cnt,
  output logic                          err,
  output logic [2:0]                    err_code,
  output logic [ORDER_W-1:0]            err_order
);
  state_t             state, state_nxt;
  err_code_t          cause;
  logic [ORDER_W-1:0] prev_order;
  logic [XLEN-1:0]    prev_wdata;
  logic               prev_trap;
  logic               order_bad, pc_bad, align_bad;
  logic               active, accept, fail;
  assign order_bad = (state == S_IDLE) ? (rvfi_order != '0) : (rvfi_order != prev_order + 64'd1);
  // a trapping predecessor redirects control, so its pc_wdata is not a valid successor
  assign pc_bad    = (state == S_TRACK) && !prev_trap && (rvfi_pc_rdata != prev_wdata);
  assign align_bad = (CHECK_ALIGN != 0) && !rvfi_trap && (rvfi_pc_wdata[1:0] != 2'b00);
  assign cause     = (state == S_HALTED) ? ERR_HALT :
                     order_bad ? ERR_ORDER :
                     pc_bad    ? ERR_PC :
                     align_bad ? ERR_ALIGN : ERR_NONE;
  assign active    = rvfi_valid && (state != S_ERROR);
  assign accept    = active && (cause == ERR_NONE);
  assign fail      = active && (cause != ERR_NONE);
  assign err       = (state == S_ERROR);
  always_comb begin
    state_nxt = state;
    if (fail) state_nxt = S_ERROR;
    else if (accept) state_nxt = rvfi_halt ? S_HALTED : S_TRACK;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_cnt <= '0;
      err_code    <= '0;
      err_order   <= '0;
      prev_order  <= '0;
      prev_wdata  <= '0;
      prev_trap   <= 1'b0;
    end else if (fail) begin
      err_code  <= cause;
      err_order <= rvfi_order;
    end else if (accept) begin
      retired_cnt <= (&retired_cnt) ? retired_cnt : retired_cnt + 32'd1;
      prev_order  <= rvfi_order;
      prev_wdata  <= rvfi_pc_wdata;
      prev_trap   <= rvfi_trap;
    end
  end
  rvfi_pc_hist #(.DEPTH(HIST_DEPTH)) u_hist (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (accept),
    .din     (rvfi_pc_rdata),
    .idx     (hist_idx),
    .dout    (hist_pc)
  );
endmodule

// File: tb/tb_rvfi_seq_monitor.sv
// tb_rvfi_seq_monitor: directed self-checking bench for rvfi_seq_monitor
module tb_rvfi_seq_monitor;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_pc_rdata = '0, rvfi_pc_wdata = '0;
  logic        rvfi_trap = 1'b0, rvfi_halt = 1'b0;
  logic [1:0]  hist_idx = '0;
  logic [31:0] hist_pc, retired_cnt, hist_pc_na, retired_cnt_na;
  logic        err, err_na;
  logic [2:0]  err_code, err_code_na;
  logic [63:0] err_order, err_order_na;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clock = ~clock;
  rvfi_seq_monitor #(.CHECK_ALIGN(1), .HIST_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .hist_idx(hist_idx), .hist_pc(hist_pc), .retired_cnt(retired_cnt),
    .err(err), .err_code(err_code), .err_order(err_order)
  );
  rvfi_seq_monitor #(.CHECK_ALIGN(0), .HIST_DEPTH(4)) dut_na (
    .clock(clock), .reset_n(reset_n), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_halt(rvfi_halt), .hist_idx(hist_idx), .hist_pc(hist_pc_na), .retired_cnt(retired_cnt_na),
    .err(err_na), .err_code(err_code_na), .err_order(err_order_na)
  );
  task automatic do_reset();
    @(negedge clock);
    rvfi_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask
  task automatic retire(input logic [63:0] o, input logic [31:0] rd, input logic [31:0] wd,
                        input logic tr, input logic hl);
    @(negedge clock);
    rvfi_valid = 1'b1; rvfi_order = o; rvfi_pc_rdata = rd; rvfi_pc_wdata = wd;
    rvfi_trap = tr; rvfi_halt = hl;
    @(posedge clock);
    #1;
    rvfi_valid = 1'b0;
  endtask
  task automatic test_reset();
    retire(0, 32'h0, 32'h4, 0, 0);
    retire(5, 32'h4, 32'h8, 0, 0);
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %0b exp 0", err); end
    n_cmp++; if (err_code !== 3'd0) begin n_bad++; $display("FAIL reset_code got %0d exp 0", err_code); end
    n_cmp++; if (err_order !== 64'd0) begin n_bad++; $display("FAIL reset_order got %0d exp 0", err_order); end
    n_cmp++; if (retired_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d exp 0", retired_cnt); end
    hist_idx = 2'd0; #1;
    n_cmp++; if (hist_pc !== 32'h0) begin n_bad++; $display("FAIL reset_hist got %h exp 0", hist_pc); end
    reset_n = 1'b1;
  endtask
  task automatic test_chain();
    do_reset();
    retire(0, 32'h0, 32'h4, 0, 0);
    retire(1, 32'h4, 32'h8, 0, 0);
    retire(2, 32'h8, 32'hC, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL chain_err got %0b exp 0", err); end
    n_cmp++; if (retired_cnt !== 32'd3) begin n_bad++; $display("FAIL chain_cnt got %0d exp 3", retired_cnt); end
    hist_idx = 2'd0; #1;
    n_cmp++; if (hist_pc !== 32'h8) begin n_bad++; $display("FAIL chain_hist0 got %h exp 8", hist_pc); end
    hist_idx = 2'd1; #1;
    n_cmp++; if (hist_pc !== 32'h4) begin n_bad++; $display("FAIL chain_hist1 got %h exp 4", hist_pc); end
    hist_idx = 2'd2; #1;
    n_cmp++; if (hist_pc !== 32'h0) begin n_bad++; $display("FAIL chain_hist2 got %h exp 0", hist_pc); end
    hist_idx = 2'd3; #1;
    n_cmp++; if (hist_pc !== 32'h0) begin n_bad++; $display("FAIL chain_hist3_unwritten got %h exp 0", hist_pc); end
  endtask
  task automatic test_order();
    do_reset();
    retire(0, 32'h0, 32'h4, 0, 0);
    retire(2, 32'h4, 32'h8, 0, 0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL order_err got %0b exp 1", err); end
    n_cmp++; if (err_code !== 3'd1) begin n_bad++; $display("FAIL order_code got %0d exp 1", err_code); end
    n_cmp++; if (err_order !== 64'd2) begin n_bad++; $display("FAIL order_at got %0d exp 2", err_order); end
    n_cmp++; if (retired_cnt !== 32'd1) begin n_bad++; $display("FAIL order_cnt got %0d exp 1", retired_cnt); end
    retire(9, 32'h4, 32'h7, 0, 0);
    n_cmp++; if (err_code !== 3'd1) begin n_bad++; $display("FAIL order_sticky_code got %0d exp 1", err_code); end
    n_cmp++; if (err_order !== 64'd2) begin n_bad++; $display("FAIL order_sticky_at got %0d exp 2", err_order); end
    n_cmp++; if (retired_cnt !== 32'd1) begin n_bad++; $display("FAIL order_sticky_cnt got %0d exp 1", retired_cnt); end
  endtask
  task automatic test_pc_chain();
    do_reset();
    retire(0, 32'h0, 32'h4, 0, 0);
    retire(1, 32'h10, 32'h14, 0, 0);
    n_cmp++; if (err_code !== 3'd2) begin n_bad++; $display("FAIL pc_code got %0d exp 2", err_code); end
    n_cmp++; if (err_order !== 64'd1) begin n_bad++; $display("FAIL pc_at got %0d exp 1", err_order); end
    hist_idx = 2'd0; #1;
    n_cmp++; if (hist_pc !== 32'h0) begin n_bad++; $display("FAIL pc_hist_unchanged got %h exp 0", hist_pc); end
    do_reset();
    retire(0, 32'h0, 32'h4, 1, 0);
    retire(1, 32'h10, 32'h14, 0, 0);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL pc_trap_err got %0b exp 0", err); end
    n_cmp++; if (retired_cnt !== 32'd2) begin n_bad++; $display("FAIL pc_trap_cnt got %0d exp 2", retired_cnt); end
    hist_idx = 2'd0; #1;
    n_cmp++; if (hist_pc !== 32'h10) begin n_bad++; $display("FAIL pc_trap_hist got %h exp 10", hist_pc); end
  endtask
  task automatic test_align();
    do_reset();
    retire(0, 32'h0, 32'h6, 0, 0);
    n_cmp++; if (err_code !== 3'd3) begin n_bad++; $display("FAIL align_code got %0d exp 3", err_code); end
    n_cmp++; if (err_na !== 1'b0) begin n_bad++; $display("FAIL align_off_err got %0b exp 0", err_na); end
    n_cmp++; if (retired_cnt_na !== 32'd1) begin n_bad++; $display("FAIL align_off_cnt got %0d exp 1", retired_cnt_na); end
    do_reset();
    retire(0, 32'h0, 32'h6, 1, 0);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL align_trap_err got %0b exp 0", err); end
  endtask
  task automatic test_halt();
    do_reset();
    retire(0, 32'h0, 32'h4, 0, 1);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL halt_first_err got %0b exp 0", err); end
    retire(1, 32'h4, 32'h8, 0, 0);
    n_cmp++; if (err_code !== 3'd4) begin n_bad++; $display("FAIL halt_code got %0d exp 4", err_code); end
    n_cmp++; if (err_order !== 64'd1) begin n_bad++; $display("FAIL halt_at got %0d exp 1", err_order); end
    do_reset();
    retire(0, 32'h100, 32'h104, 0, 0);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL halt_rst_err got %0b exp 0", err); end
    n_cmp++; if (retired_cnt !== 32'd1) begin n_bad++; $display("FAIL halt_rst_cnt got %0d exp 1", retired_cnt); end
    do_reset();
    retire(1, 32'h104, 32'h108, 0, 0);
    n_cmp++; if (err_code !== 3'd1) begin n_bad++; $display("FAIL midrst_code got %0d exp 1", err_code); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) retire(64'(i), 32'(4 * i), 32'(4 * i + 4), 0, 0);
    n_cmp++; if (retired_cnt !== 32'd6) begin n_bad++; $display("FAIL wrap_cnt got %0d exp 6", retired_cnt); end
    hist_idx = 2'd3; #1;
    n_cmp++; if (hist_pc !== 32'h8) begin n_bad++; $display("FAIL wrap_hist3 got %h exp 8", hist_pc); end
    hist_idx = 2'd0; #1;
    n_cmp++; if (hist_pc !== 32'h14) begin n_bad++; $display("FAIL wrap_hist0 got %h exp 14", hist_pc); end
    retire(7, 32'h40, 32'h45, 0, 0);
    n_cmp++; if (err_code !== 3'd1) begin n_bad++; $display("FAIL prio_code got %0d exp 1", err_code); end
    n_cmp++; if (err_order !== 64'd7) begin n_bad++; $display("FAIL prio_at got %0d exp 7", err_order); end
    do_reset();
    retire(0, 32'h0, 32'h4, 0, 0);
    retire(1, 32'h20, 32'h26, 0, 0);
    n_cmp++; if (err_code !== 3'd2) begin n_bad++; $display("FAIL prio_pc_over_align got %0d exp 2", err_code); end
    n_cmp++; if (err_code_na !== 3'd2) begin n_bad++; $display("FAIL prio_pc_noalign got %0d exp 2", err_code_na); end
  endtask
  initial begin
    test_reset();
    test_chain();
    test_order();
    test_pc_chain();
    test_align();
    test_halt();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rvfi_seq_monitor.md
RVFI_SEQ_MONITOR -- requirements
Module: rvfi_seq_monitor

Interface
REQ-001 SHALL have parameter CHECK_ALIGN, default 1; 1 enables the 4-byte PC alignment check.
REQ-002 SHALL have parameter HIST_DEPTH, default 4, legal value a power of 2 from 2 to 16; sets the retired-PC history depth.
REQ-003 clock  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 rvfi_valid  in  1  one retirement this cycle.
REQ-006 rvfi_order  in  64  retirement index.
REQ-007 rvfi_pc_rdata / rvfi_pc_wdata  in  32 each  PC of the retired insn / next PC.
REQ-008 rvfi_trap, rvfi_halt  in  1 each  retirement trapped / core halted.
REQ-009 hist_idx  in  $clog2(HIST_DEPTH)  history read index; 0 = newest.
REQ-010 hist_pc  out  32  pc_rdata of the entry at hist_idx, read combinationally from registered storage.
REQ-011 retired_cnt  out  32  count of accepted retirements.
REQ-012 err  out  1  sticky error flag.
REQ-013 err_code  out  3  first error cause: 0 none, 1 order, 2 pc-chain, 3 align, 4 post-halt.
REQ-014 err_order  out  64  rvfi_order of the first failing retirement.

Function
REQ-015 SHALL implement FSM states IDLE, TRACK, HALTED, ERROR.
REQ-016 IDLE, rvfi_valid with rvfi_order==0 and no other check failing: record, go to TRACK, or go to HALTED if rvfi_halt.
REQ-017 IDLE, rvfi_valid with rvfi_order!=0: go to ERROR with code 1.
REQ-018 TRACK: the expected order SHALL equal the previous order+1, with 64-bit wrap; a mismatch gives code 1.
REQ-019 TRACK: when the previous retirement had rvfi_trap==0, rvfi_pc_rdata SHALL equal the previous rvfi_pc_wdata, else code 2; the pc check is skipped when the previous retirement trapped.
REQ-020 With CHECK_ALIGN=1 in IDLE or TRACK: rvfi_pc_wdata[1:0]!=0 on a non-trapping retirement gives code 3.
REQ-021 When several checks fail in one cycle, priority SHALL be 1 > 2 > 3.
REQ-022 HALTED: any rvfi_valid gives code 4.
REQ-023 ERROR is absorbing until reset.
REQ-024 On entry to ERROR: err=1, err_code and err_order captured once, never overwritten.
REQ-025 Each accepted retirement (no error) SHALL:
  - increment retired_cnt, saturating at 32'hFFFF_FFFF;
  - push rvfi_pc_rdata into the history as the newest entry;
  - store previous order, pc_wdata and trap.
REQ-026 A failing retirement SHALL NOT update retired_cnt or the history.
REQ-027 Latency: err and err_code SHALL assert the cycle after the offending rvfi_valid edge.
REQ-028 Cycles with rvfi_valid=0 SHALL change no state.
REQ-029 History SHALL be a circular buffer indexed by a write pointer that wraps modulo HIST_DEPTH; hist_idx maps to (wptr-1-hist_idx) mod HIST_DEPTH.
REQ-030 hist_pc SHALL read 0 for history entries not yet written since reset.

Reset
REQ-031 reset_n low SHALL asynchronously force:
  - FSM to IDLE;
  - retired_cnt=0, err=0, err_code=0, err_order=0;
  - history storage and write pointer to 0;
  - previous-retirement registers to 0.
REQ-032 Reset asserted mid-stream SHALL discard all tracking; the first retirement after release is checked as IDLE (requires order 0).

Structure
REQ-033 A shared package rvfi_mon_pkg SHALL hold:
  - the FSM state enum;
  - the err_code enum (ERR_NONE, ERR_ORDER, ERR_PC, ERR_ALIGN, ERR_HALT);
  - the XLEN=32 and ORDER_W=64 constants.
REQ-034 The history buffer SHALL be one sub-module, rvfi_pc_hist (parameter DEPTH; ports push, din, idx, dout).

Verification
REQ-035 Orders 0,1,2 with a consistent pc chain 0x0→0x4→0x8 → err=0, retired_cnt=3; hist_idx=0 gives 0x8 and hist_idx=2 gives 0x0.
REQ-036 Order 0, then order 2 → err=1, err_code=1, err_order=2, retired_cnt=1.
REQ-037 Order 0 with pc_wdata=0x4, then order 1 with pc_rdata=0x10 and trap=0 → err_code=2. The same sequence with the first retirement trap=1 → no error.
REQ-038 Non-trapping retirement with pc_wdata=0x6 → err_code=3 at CHECK_ALIGN=1; no error at CHECK_ALIGN=0.
REQ-039 Retirement with rvfi_halt=1, then any rvfi_valid → err_code=4. Then pulse reset_n low and send order 0 → err=0, retired_cnt=1.
REQ-040 Six retirements at HIST_DEPTH=4 → hist_idx=3 returns the pc of the 3rd retirement (wrap check); an order mismatch and a pc mismatch in the same cycle → err_code=1.
